sram_2p_bank: RTL and testbench
===============================

Name: sram_2p_bank

Overview:
- Parametrised two-port synchronous SRAM bank: one write port and one read port.
- Generalises the single-port instruction/data memory model in four ways: configurable data width, registered read latency of 1 or 2 cycles, selectable read-during-write policy, and a hardware clear engine.
- Sits between the pipeline MEM stage (or a cache refill path) and backing storage.
- Reports out-of-range accesses through a sticky error flag.

Parameters:
- DWIDTH, 32: data width in bits; must be a multiple of 8.
- AWIDTH, 12: address width.
- SIZE, 4096: number of words; SIZE <= 2^AWIDTH.
- READ_LAT, 1: read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0: same-address read-during-write result; 0 = old data, 1 = new (merged) data.
- CLEAR_ON_RST, 1: 1 = zero the whole array after reset; 0 = skip clearing.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  synchronous reset, active-high.
- WCSN  input  1  write-port select, active-low.
- WADDR  input  AWIDTH  write word address.
- WBE  input  DWIDTH/8  byte-lane write enables.
- WDI  input  DWIDTH  write data.
- RCSN  input  1  read-port select, active-low.
- RADDR  input  AWIDTH  read word address.
- RDOUT  output  DWIDTH  registered read data.
- RVALID  output  1  one-cycle pulse; RDOUT carries a new read result.
- BUSY  output  1  clear engine active; both ports ignored.
- ERR  output  1  sticky: an out-of-range access has occurred.

Behaviour:
- Reset (RST=1 at a posedge):
  - RDOUT=0, RVALID=0, ERR=0.
  - Read pipeline flushed; clear counter=0.
  - Next state is CLEAR if CLEAR_ON_RST=1, else IDLE.
  - BUSY=1 in the cycle after the reset edge when CLEAR_ON_RST=1.
  - Reset asserted mid-clear restarts the counter at 0.
  - Array contents are not otherwise touched by reset.
- FSM states: IDLE, CLEAR.
- CLEAR:
  - Each posedge writes 0 to ram[cnt], then cnt++.
  - After the edge that writes ram[SIZE-1], go to IDLE. Total duration: SIZE cycles.
  - BUSY=1 throughout CLEAR.
  - WCSN/RCSN are ignored: no writes, no reads, RVALID stays 0, ERR not updated.
- IDLE write (posedge with WCSN=0):
  - Lane i (bits 8i+7:8i) is updated from WDI only if WBE[i]=1.
  - WBE=0 is a legal no-op.
  - WADDR >= SIZE: write dropped, ERR set.
- IDLE read (posedge N with RCSN=0):
  - Array sampled at edge N.
  - READ_LAT=1: RDOUT updated and RVALID=1 after edge N.
  - READ_LAT=2: RDOUT updated and RVALID=1 after edge N+1.
  - Back-to-back reads give one result per cycle, in order.
  - RADDR >= SIZE: result is 0, RVALID still pulses, ERR set.
- RVALID and RDOUT hold:
  - RVALID=0 in any cycle without a completing read.
  - RDOUT holds its last value between reads.
- Simultaneous read and write, same address, same edge:
  - RDW_MODE=0: read returns the pre-write word.
  - RDW_MODE=1: read returns the old word with the WBE-enabled lanes replaced by WDI.
- Simultaneous read and write, different addresses: fully independent.
- ERR is cleared only by RST.
- No combinational path from any input to RDOUT or RVALID.

Test Plan:
- CLEAR_ON_RST=1, SIZE=16: pulse RST for 1 cycle -> BUSY=1 for exactly 16 cycles. Then read addr 0..15 -> all 0x00000000. Write issued during BUSY is lost.
- Write 0xDEADBEEF to addr 5 with WBE=4'b1111, then write 0x11223344 with WBE=4'b0101 -> read addr 5 returns 0xDE22BE44.
- READ_LAT=2: read at edges N, N+1 (addr 3, addr 4) -> RVALID high after edges N+1 and N+2, data in order. RVALID=0 on the following idle cycle.
- Addr 7 holds 0xAAAAAAAA; same-edge write 0x55555555 (WBE=4'b0011) and read of addr 7 -> RDW_MODE=0 gives 0xAAAAAAAA; RDW_MODE=1 gives 0xAAAA5555.
- SIZE=3000, AWIDTH=12: write addr 3000 -> ERR=1, no array change. Read addr 3001 -> RDOUT=0, RVALID=1. ERR stays 1 until RST.
- Assert RST at clear count 8 of 16 -> counter restarts. BUSY lasts a further 16 cycles after the reset edge.

Source files
------------

// File: rtl/sram_2p_bank.sv
// Two-port synchronous SRAM bank with one write port and one read port.
// It supports byte-lane writes, a read latency of 1 or 2 cycles and a
// selectable same-address read-during-write result. A clear engine zeroes
// the array after reset. ERR is a sticky flag for out-of-range accesses.
module sram_2p_bank #(
    parameter int DWIDTH       = 32,
    parameter int AWIDTH       = 12,
    parameter int SIZE         = 4096,
    parameter int READ_LAT     = 1,
    parameter int RDW_MODE     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WCSN,
    input  logic [AWIDTH-1:0]   WADDR,
    input  logic [DWIDTH/8-1:0] WBE,
    input  logic [DWIDTH-1:0]   WDI,
    input  logic                RCSN,
    input  logic [AWIDTH-1:0]   RADDR,
    output logic [DWIDTH-1:0]   RDOUT,
    output logic                RVALID,
    output logic                BUSY,
    output logic                ERR
);

    localparam int NLANES = DWIDTH / 8;
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [AWIDTH:0] SIZE_EXT = (AWIDTH + 1)'(SIZE);
    localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     clearCnt_q, clearCnt_d;
    logic [DWIDTH-1:0] mem [SIZE];

    logic              wrSel, rdSel, wrInRange, rdInRange, wrEn, rdEn;
    logic [IW-1:0]     wIdx, rIdx;
    logic [DWIDTH-1:0] oldWord, mergedWord, rdResult;

    logic              stageValid;
    logic [DWIDTH-1:0] stageData;
    logic              rdValid_q;
    logic [DWIDTH-1:0] rdData_q;
    logic              err_q;

    // Decode the port requests and form the word a read returns this edge.
    always_comb begin
        wrSel      = (state_q == IDLE) && !WCSN;
        rdSel      = (state_q == IDLE) && !RCSN;
        wrInRange  = {1'b0, WADDR} < SIZE_EXT;
        rdInRange  = {1'b0, RADDR} < SIZE_EXT;
        wrEn       = wrSel && wrInRange;
        rdEn       = rdSel;
        wIdx       = WADDR[IW-1:0];
        rIdx       = RADDR[IW-1:0];
        oldWord    = mem[rIdx];
        mergedWord = oldWord;
        for (int i = 0; i < NLANES; i++) begin
            if (WBE[i]) begin
                mergedWord[8*i +: 8] = WDI[8*i +: 8];
            end
        end
        rdResult = '0;
        if (rdInRange) begin
            if ((RDW_MODE == 1) && wrEn && (WADDR == RADDR)) begin
                rdResult = mergedWord;
            end else begin
                rdResult = oldWord;
            end
        end
    end

    // Compute the next state and counter value for the clear engine.
    always_comb begin
        state_d    = state_q;
        clearCnt_d = clearCnt_q;
        if (state_q == CLEAR) begin
            if (clearCnt_q == LAST_IDX) begin
                state_d    = IDLE;
                clearCnt_d = '0;
            end else begin
                clearCnt_d = clearCnt_q + 1'b1;
            end
        end
    end

    // Update the state register. Reset restarts the clear from word 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
            clearCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            clearCnt_q <= clearCnt_d;
        end
    end

    // Update the array. Each edge applies either a clear step or a lane-masked write.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_q == CLEAR) begin
                mem[clearCnt_q] <= '0;
            end else if (wrEn) begin
                for (int i = 0; i < NLANES; i++) begin
                    if (WBE[i]) begin
                        mem[wIdx][8*i +: 8] <= WDI[8*i +: 8];
                    end
                end
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic              s1Valid_q;
        logic [DWIDTH-1:0] s1Data_q;

        // Hold a read for one extra cycle before it reaches the output register.
        always_ff @(posedge CLK) begin
            if (RST) begin
                s1Valid_q <= 1'b0;
                s1Data_q  <= '0;
            end else begin
                s1Valid_q <= rdEn;
                if (rdEn) begin
                    s1Data_q <= rdResult;
                end
            end
        end

        assign stageValid = s1Valid_q;
        assign stageData  = s1Data_q;
    end else begin : g_lat1
        assign stageValid = rdEn;
        assign stageData  = rdResult;
    end

    // Update the output register. RDOUT keeps its last value between reads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdValid_q <= 1'b0;
            rdData_q  <= '0;
        end else begin
            rdValid_q <= stageValid;
            if (stageValid) begin
                rdData_q <= stageData;
            end
        end
    end

    // Latch ERR on any out-of-range access that is accepted outside the clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if ((wrSel && !wrInRange) || (rdSel && !rdInRange)) begin
            err_q <= 1'b1;
        end
    end

    assign RDOUT  = rdData_q;
    assign RVALID = rdValid_q;
    assign BUSY   = (state_q == CLEAR);
    assign ERR    = err_q;

endmodule

// File: tb/tb_sram_2p_bank.sv
// Self-checking bench for sram_2p_bank. Three instances cover different
// parameter sets: A (16 words, latency 1, old-data), B (16 words, latency 2,
// merged data) and C (3000 words, latency 1, no clear). Read results go
// through per-instance expectation queues, which a negedge monitor drains.
module tb_sram_2p_bank;

    logic        clk;
    logic        rst    [3];
    logic        wcsn   [3];
    logic [11:0] waddr  [3];
    logic [3:0]  wbe    [3];
    logic [31:0] wdi    [3];
    logic        rcsn   [3];
    logic [11:0] raddr  [3];
    logic [31:0] rdout  [3];
    logic        rvalid [3];
    logic        busy   [3];
    logic        err    [3];

    logic [31:0] expQ0 [$];
    logic [31:0] expQ1 [$];
    logic [31:0] expQ2 [$];

    int  checks;
    int  errors;
    bit  monitorOn;
    int  n;

    sram_2p_bank #(.DWIDTH(32), .AWIDTH(12), .SIZE(16), .READ_LAT(1),
                   .RDW_MODE(0), .CLEAR_ON_RST(1)) dutA (
        .CLK(clk), .RST(rst[0]), .WCSN(wcsn[0]), .WADDR(waddr[0]), .WBE(wbe[0]),
        .WDI(wdi[0]), .RCSN(rcsn[0]), .RADDR(raddr[0]), .RDOUT(rdout[0]),
        .RVALID(rvalid[0]), .BUSY(busy[0]), .ERR(err[0]));

    sram_2p_bank #(.DWIDTH(32), .AWIDTH(12), .SIZE(16), .READ_LAT(2),
                   .RDW_MODE(1), .CLEAR_ON_RST(1)) dutB (
        .CLK(clk), .RST(rst[1]), .WCSN(wcsn[1]), .WADDR(waddr[1]), .WBE(wbe[1]),
        .WDI(wdi[1]), .RCSN(rcsn[1]), .RADDR(raddr[1]), .RDOUT(rdout[1]),
        .RVALID(rvalid[1]), .BUSY(busy[1]), .ERR(err[1]));

    sram_2p_bank #(.DWIDTH(32), .AWIDTH(12), .SIZE(3000), .READ_LAT(1),
                   .RDW_MODE(0), .CLEAR_ON_RST(0)) dutC (
        .CLK(clk), .RST(rst[2]), .WCSN(wcsn[2]), .WADDR(waddr[2]), .WBE(wbe[2]),
        .WDI(wdi[2]), .RCSN(rcsn[2]), .RADDR(raddr[2]), .RDOUT(rdout[2]),
        .RVALID(rvalid[2]), .BUSY(busy[2]), .ERR(err[2]));

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        wcsn[k] = 1'b1;
        rcsn[k] = 1'b1;
    endtask

    task automatic driveRaw(input int k, input bit doW, input logic [11:0] wa, input logic [3:0] be,
                            input logic [31:0] wd, input bit doR, input logic [11:0] ra);
        wcsn[k]  = !doW;
        waddr[k] = wa;
        wbe[k]   = be;
        wdi[k]   = wd;
        rcsn[k]  = !doR;
        raddr[k] = ra;
    endtask

    task automatic pushExp(input int k, input logic [31:0] v);
        case (k)
            0:       expQ0.push_back(v);
            1:       expQ1.push_back(v);
            default: expQ2.push_back(v);
        endcase
    endtask

    task automatic applyStimulus(input int k, input bit doW, input logic [11:0] wa, input logic [3:0] be,
                                 input logic [31:0] wd, input bit doR, input logic [11:0] ra,
                                 input logic [31:0] expRd);
        if (doR) pushExp(k, expRd);
        driveRaw(k, doW, wa, be, wd, doR, ra);
        tick();
        idle(k);
    endtask

    task automatic applyReset(input int k);
        idle(k);
        rst[k] = 1'b1;
        tick();
        rst[k] = 1'b0;
    endtask

    task automatic waitBusyLow(input int k, output int cycles);
        cycles = 0;
        while (busy[k] && cycles < 200) begin
            cycles++;
            tick();
        end
    endtask

    task automatic scoreboardPop(input int k);
        logic [31:0] exp;
        bit          have;
        have = 1'b0;
        exp  = '0;
        case (k)
            0: if (expQ0.size() > 0) begin exp = expQ0.pop_front(); have = 1'b1; end
            1: if (expQ1.size() > 0) begin exp = expQ1.pop_front(); have = 1'b1; end
            default: if (expQ2.size() > 0) begin exp = expQ2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rvalid dut%0d actual=%h expected=no_read", k, rdout[k]);
        end else begin
            checkOutput($sformatf("rdout_dut%0d", k), rdout[k], exp);
        end
    endtask

    // Compare every completed read against the oldest expectation for that instance.
    always @(negedge clk) begin
        if (monitorOn) begin
            for (int k = 0; k < 3; k++) begin
                if (rvalid[k]) scoreboardPop(k);
            end
        end
    end

    // Directed test sequence for all three instances.
    initial begin
        checks    = 0;
        errors    = 0;
        monitorOn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            driveRaw(k, 1'b0, 12'd0, 4'h0, 32'h0, 1'b0, 12'd0);
            idle(k);
            rst[k] = 1'b1;
        end
        tick();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        monitorOn = 1'b1;

        // Reset state
        checkOutput("A_rdout_reset", rdout[0], 32'h0);
        checkOutput("A_rvalid_reset", {31'b0, rvalid[0]}, 32'h0);
        checkOutput("A_err_reset", {31'b0, err[0]}, 32'h0);
        checkOutput("A_busy_after_reset", {31'b0, busy[0]}, 32'h1);
        checkOutput("C_busy_no_clear", {31'b0, busy[2]}, 32'h0);

        // First clear takes SIZE cycles
        waitBusyLow(0, n);
        checkOutput("A_busy_cycles_first", 32'(n), 32'd16);

        // Reset in the middle of a clear restarts the counter
        applyReset(0);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("A_busy_mid_clear", {31'b0, busy[0]}, 32'h1);
        applyReset(0);
        n = 0;
        while (busy[0] && n < 100) begin
            n++;
            if (n == 10)      driveRaw(0, 1'b1, 12'd2, 4'hF, 32'h12345678, 1'b1, 12'd2);
            else if (n == 11) driveRaw(0, 1'b1, 12'd20, 4'hF, 32'h1, 1'b1, 12'd21);
            else              idle(0);
            tick();
        end
        idle(0);
        checkOutput("A_busy_cycles_restart", 32'(n), 32'd16);
        checkOutput("A_err_ignored_in_clear", {31'b0, err[0]}, 32'h0);

        // Every word reads as zero, including the one written during BUSY
        for (int i = 0; i < 16; i++) applyStimulus(0, 1'b0, 12'd0, 4'h0, 32'h0, 1'b1, 12'(i), 32'h0);

        // Byte-lane write merge
        applyStimulus(0, 1'b1, 12'd5, 4'hF, 32'hDEADBEEF, 1'b0, 12'd0, 32'h0);
        applyStimulus(0, 1'b1, 12'd5, 4'b0101, 32'h11223344, 1'b0, 12'd0, 32'h0);
        applyStimulus(0, 1'b0, 12'd0, 4'h0, 32'h0, 1'b1, 12'd5, 32'hDE22BE44);

        // Same-address read-during-write, old-data mode
        applyStimulus(0, 1'b1, 12'd7, 4'hF, 32'hAAAAAAAA, 1'b0, 12'd0, 32'h0);
        applyStimulus(0, 1'b1, 12'd7, 4'b0011, 32'h55555555, 1'b1, 12'd7, 32'hAAAAAAAA);
        applyStimulus(0, 1'b0, 12'd0, 4'h0, 32'h0, 1'b1, 12'd7, 32'hAAAA5555);

        // Different-address write and read on the same edge are independent
        applyStimulus(0, 1'b1, 12'd9, 4'hF, 32'hCAFEF00D, 1'b1, 12'd5, 32'hDE22BE44);
        applyStimulus(0, 1'b0, 12'd0, 4'h0, 32'h0, 1'b1, 12'd9, 32'hCAFEF00D);
        tick();
        checkOutput("A_rvalid_idle", {31'b0, rvalid[0]}, 32'h0);
        checkOutput("A_rdout_hold", rdout[0], 32'hCAFEF00D);

        // WBE of zero writes nothing
        applyStimulus(0, 1'b1, 12'd9, 4'h0, 32'hFFFFFFFF, 1'b0, 12'd0, 32'h0);
        applyStimulus(0, 1'b0, 12'd0, 4'h0, 32'h0, 1'b1, 12'd9, 32'hCAFEF00D);
        checkOutput("A_err_still_clear", {31'b0, err[0]}, 32'h0);

        // Out-of-range read whose low address bits alias a live word
        applyStimulus(0, 1'b1, 12'd4, 4'hF, 32'h00000044, 1'b0, 12'd0, 32'h0);
        applyStimulus(0, 1'b0, 12'd0, 4'h0, 32'h0, 1'b1, 12'd20, 32'h0);
        checkOutput("A_err_oor_read", {31'b0, err[0]}, 32'h1);
        applyStimulus(0, 1'b0, 12'd0, 4'h0, 32'h0, 1'b1, 12'd4, 32'h00000044);

        // Latency-2 instance: back-to-back reads arrive in order one cycle later
        waitBusyLow(1, n);
        checkOutput("B_busy_done", {31'b0, busy[1]}, 32'h0);
        applyStimulus(1, 1'b1, 12'd3, 4'hF, 32'h33333333, 1'b0, 12'd0, 32'h0);
        applyStimulus(1, 1'b1, 12'd4, 4'hF, 32'h44444444, 1'b0, 12'd0, 32'h0);
        applyStimulus(1, 1'b0, 12'd0, 4'h0, 32'h0, 1'b1, 12'd3, 32'h33333333);
        checkOutput("B_rvalid_after_N", {31'b0, rvalid[1]}, 32'h0);
        applyStimulus(1, 1'b0, 12'd0, 4'h0, 32'h0, 1'b1, 12'd4, 32'h44444444);
        checkOutput("B_rvalid_after_N1", {31'b0, rvalid[1]}, 32'h1);
        checkOutput("B_rdout_after_N1", rdout[1], 32'h33333333);
        tick();
        checkOutput("B_rvalid_after_N2", {31'b0, rvalid[1]}, 32'h1);
        checkOutput("B_rdout_after_N2", rdout[1], 32'h44444444);
        tick();
        checkOutput("B_rvalid_after_N3", {31'b0, rvalid[1]}, 32'h0);

        // Same-address read-during-write, merged-data mode
        applyStimulus(1, 1'b1, 12'd7, 4'hF, 32'hAAAAAAAA, 1'b0, 12'd0, 32'h0);
        applyStimulus(1, 1'b1, 12'd7, 4'b0011, 32'h55555555, 1'b1, 12'd7, 32'hAAAA5555);
        tick();
        tick();

        // Large, non-power-of-two instance: out-of-range access and sticky ERR
        applyStimulus(2, 1'b1, 12'd10, 4'hF, 32'h0BADCAFE, 1'b0, 12'd0, 32'h0);
        applyStimulus(2, 1'b0, 12'd0, 4'h0, 32'h0, 1'b1, 12'd10, 32'h0BADCAFE);
        checkOutput("C_err_in_range", {31'b0, err[2]}, 32'h0);
        applyStimulus(2, 1'b1, 12'd3000, 4'hF, 32'h12345678, 1'b0, 12'd0, 32'h0);
        checkOutput("C_err_oor_write", {31'b0, err[2]}, 32'h1);
        applyStimulus(2, 1'b0, 12'd0, 4'h0, 32'h0, 1'b1, 12'd3001, 32'h0);
        checkOutput("C_rvalid_oor_read", {31'b0, rvalid[2]}, 32'h1);
        applyStimulus(2, 1'b0, 12'd0, 4'h0, 32'h0, 1'b1, 12'd10, 32'h0BADCAFE);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("C_err_sticky", {31'b0, err[2]}, 32'h1);
        applyReset(2);
        checkOutput("C_err_after_reset", {31'b0, err[2]}, 32'h0);

        // Every issued read must have been answered
        for (int i = 0; i < 4; i++) tick();
        checkOutput("A_queue_empty", 32'(expQ0.size()), 32'd0);
        checkOutput("B_queue_empty", 32'(expQ1.size()), 32'd0);
        checkOutput("C_queue_empty", 32'(expQ2.size()), 32'd0);

        monitorOn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
